// File: rtl/axis_split_dest.sv
// axis_split_dest: packet-aware AXI-Stream demultiplexer.
// One slave stream fans out to MASTER_NUM master streams. The destination is
// taken from tdest on the first beat of a packet and held through tlast.
// A single registered output stage gives 1-cycle latency at full throughput.
// Packets addressed to a port index >= MASTER_NUM are swallowed and counted.
module axis_split_dest #(
  parameter int unsigned MASTER_NUM = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEST_WIDTH = $clog2(MASTER_NUM),
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  arstn,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [MASTER_NUM-1:0] m_axis_tvalid,
  input  logic [MASTER_NUM-1:0] m_axis_tready,

  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic                  drop_pulse
);

  // Output stage
  logic                  ov_q, ov_d;
  logic [MASTER_NUM-1:0] osel_q, osel_d;
  logic [DATA_WIDTH-1:0] od_q, od_d;
  logic                  ol_q, ol_d;

  // Packet tracking
  logic                  sop_q, sop_d;
  logic [DEST_WIDTH-1:0] route_q, route_d;
  logic                  dropping_q, dropping_d;

  // Statistics
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
  logic                  drop_pulse_q, drop_pulse_d;

  // Handshake / routing helpers
  logic                  s_hs;
  logic                  m_hs;
  logic                  dest_invalid;
  logic                  drop_now;
  logic                  fwd_beat;
  logic                  drop_beat;
  logic [DEST_WIDTH-1:0] sel_idx;
  logic [MASTER_NUM-1:0] sel_oh;

  // Only the selected port's tready can drain the output stage.
  assign m_hs         = ov_q & (|(osel_q & m_axis_tready));

  // Zero-extend before comparing so any DEST_WIDTH works against MASTER_NUM.
  assign dest_invalid = (32'(s_axis_tdest) >= MASTER_NUM);

  assign drop_now     = (sop_q & s_axis_tvalid & dest_invalid) | dropping_q;

  // Dropped beats never touch the output stage, so they are always accepted.
  assign s_axis_tready = drop_now ? 1'b1 : (~ov_q | m_hs);

  assign s_hs      = s_axis_tvalid & s_axis_tready;
  assign fwd_beat  = s_hs & ~drop_now;
  assign drop_beat = s_hs & drop_now;

  // First beat routes by its own tdest; later beats follow the latched route.
  assign sel_idx = sop_q ? s_axis_tdest : route_q;
  assign sel_oh  = {{(MASTER_NUM - 1){1'b0}}, 1'b1} << sel_idx;

  // Output stage next state: load on a forwarded beat, empty on a bare drain.
  always_comb begin
    ov_d   = ov_q;
    osel_d = osel_q;
    od_d   = od_q;
    ol_d   = ol_q;
    if (fwd_beat) begin
      ov_d   = 1'b1;
      osel_d = sel_oh;
      od_d   = s_axis_tdata;
      ol_d   = s_axis_tlast;
    end else if (m_hs) begin
      ov_d   = 1'b0;
    end
  end

  // Packet tracking next state: sop, latched route and drop-in-progress flag.
  always_comb begin
    sop_d      = sop_q;
    route_d    = route_q;
    dropping_d = dropping_q;
    if (fwd_beat) begin
      if (sop_q) begin
        route_d = s_axis_tdest;
      end
      sop_d = s_axis_tlast;
    end else if (drop_beat) begin
      dropping_d = ~s_axis_tlast;
      sop_d      = s_axis_tlast;
    end
  end

  // Statistics next state: count and pulse once per dropped packet.
  always_comb begin
    drop_cnt_d   = drop_cnt_q;
    drop_pulse_d = 1'b0;
    if (drop_beat && sop_q) begin
      drop_pulse_d = 1'b1;
      if (drop_cnt_q != {CNT_WIDTH{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end
  end

  // Output stage registers.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      ov_q   <= 1'b0;
      osel_q <= '0;
      od_q   <= '0;
      ol_q   <= 1'b0;
    end else begin
      ov_q   <= ov_d;
      osel_q <= osel_d;
      od_q   <= od_d;
      ol_q   <= ol_d;
    end
  end

  // Packet tracking registers; reset returns to start-of-packet.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      sop_q      <= 1'b1;
      route_q    <= '0;
      dropping_q <= 1'b0;
    end else begin
      sop_q      <= sop_d;
      route_q    <= route_d;
      dropping_q <= dropping_d;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      drop_cnt_q   <= drop_cnt_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  assign m_axis_tvalid = osel_q & {MASTER_NUM{ov_q}};
  assign m_axis_tdata  = od_q;
  assign m_axis_tlast  = ol_q;
  assign drop_cnt      = drop_cnt_q;
  assign drop_pulse    = drop_pulse_q;

endmodule

// File: tb/tb_axis_split_dest.sv
// Testbench for axis_split_dest: three ports, 2-bit tdest (value 3 is invalid),
// 3-bit drop counter so saturation is reachable. Stimulus pushes expected
// beats and drop pulses into queues; a negedge monitor pops and compares.
module tb_axis_split_dest;

  localparam int MN = 3;
  localparam int DW = 32;
  localparam int TW = 2;
  localparam int CW = 3;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          arstn;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [TW-1:0] s_axis_tdest;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic [MN-1:0] m_axis_tvalid;
  logic [MN-1:0] m_axis_tready;
  logic [CW-1:0] drop_cnt;
  logic          drop_pulse;

  axis_split_dest #(
    .MASTER_NUM(MN),
    .DATA_WIDTH(DW),
    .DEST_WIDTH(TW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .arstn        (arstn),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tdest (s_axis_tdest),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .drop_cnt     (drop_cnt),
    .drop_pulse   (drop_pulse)
  );

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    logic          last;
    int            at_cyc;
  } item_t;

  item_t sb_q[$];   // in-order expected deliveries
  item_t lat_q[$];  // same beats, checked at their exact due cycle
  int    pq[$];     // cycle numbers at which drop_pulse is due

  int n_cmp   = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int exp_cnt = 0;
  bit rdy_rand = 0;
  bit strict   = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Random per-port backpressure when enabled.
  always @(posedge clk) begin
    if (rdy_rand) begin
      #1;
      for (int i = 0; i < MN; i++) m_axis_tready[i] = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Drives one beat (entered at posedge+1) and waits for its handshake.
  task automatic send_beat(input logic [TW-1:0] td, input logic [DW-1:0] d, input logic l,
                           input int port, input bit first);
    bit    done;
    item_t it;
    done = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdest  = td;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    for (int w = 0; w < 300 && !done; w++) begin
      @(negedge clk);
      if (w == 0 && port < 0) chk("drop_ready", 64'(s_axis_tready), 64'd1);
      else if (w == 0 && strict) chk("no_bubble", 64'(s_axis_tready), 64'd1);
      if (s_axis_tready) begin
        done = 1;
        if (port >= 0) begin
          it.port = port; it.data = d; it.last = l; it.at_cyc = cyc + 1;
          sb_q.push_back(it);
          lat_q.push_back(it);
        end else if (first) begin
          pq.push_back(cyc + 1);
        end
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL handshake_timeout: tready stayed %0b, required 1", s_axis_tready);
    end
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = $urandom;
    s_axis_tdest  = TW'($urandom);
    s_axis_tlast  = 1'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Packet-level model: a valid dest delivers every beat to that port in
  // order; an invalid dest delivers nothing and produces one drop pulse.
  task automatic send_pkt(input int dest, input int len, input int alt, input bit gaps);
    int port;
    int td;
    port = (dest < MN) ? dest : -1;
    for (int i = 0; i < len; i++) begin
      td = (i == 0) ? dest : ((alt >= 0) ? alt : int'($urandom_range(0, 3)));
      send_beat(TW'(td), $urandom, (i == len - 1), port, (i == 0));
      if (gaps && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
  endtask

  // Monitor: protocol, latency, scoreboard and drop-pulse checks.
  logic          prev_v, prev_hs, prev_l;
  logic [MN-1:0] prev_valid;
  logic [DW-1:0] prev_d;
  always @(negedge clk) begin
    bit    hs;
    bit    exp_p;
    item_t it;
    if (!arstn) begin
      prev_v = 1'b0;
    end else begin
      if ($countones(m_axis_tvalid) > 1) chk("onehot_valid", 64'(m_axis_tvalid), 64'd0);
      if (prev_v && !prev_hs) begin
        chk("stall_valid", 64'(m_axis_tvalid), 64'(prev_valid));
        chk("stall_data", 64'(m_axis_tdata), 64'(prev_d));
        chk("stall_last", 64'(m_axis_tlast), 64'(prev_l));
      end
      if (lat_q.size() > 0 && lat_q[0].at_cyc == cyc) begin
        it = lat_q.pop_front();
        chk("lat_valid", 64'(m_axis_tvalid), 64'd1 << it.port);
        chk("lat_data", 64'(m_axis_tdata), 64'(it.data));
      end
      hs = |(m_axis_tvalid & m_axis_tready);
      if (hs) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: valid %b data %0h, required no output",
                   m_axis_tvalid, m_axis_tdata);
        end else begin
          it = sb_q.pop_front();
          chk("sb_port", 64'(m_axis_tvalid), 64'd1 << it.port);
          chk("sb_data", 64'(m_axis_tdata), 64'(it.data));
          chk("sb_last", 64'(m_axis_tlast), 64'(it.last));
        end
      end
      exp_p = (pq.size() > 0 && pq[0] == cyc);
      if (exp_p) begin
        void'(pq.pop_front());
        if (exp_cnt < CNT_MAX) exp_cnt++;
      end
      if (exp_p || drop_pulse) chk("drop_pulse", 64'(drop_pulse), 64'(exp_p));
      if (exp_p) chk("drop_cnt", 64'(drop_cnt), 64'(exp_cnt));
      prev_v     = |m_axis_tvalid;
      prev_hs    = hs;
      prev_valid = m_axis_tvalid;
      prev_d     = m_axis_tdata;
      prev_l     = m_axis_tlast;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arstn         = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tdest  = '0;
    m_axis_tready = '1;
    #2 arstn = 1'b0;

    // Reset state with a valid beat waiting.
    @(negedge clk);
    chk("rst_tready", 64'(s_axis_tready), 64'd1);
    chk("rst_valid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_data", 64'(m_axis_tdata), 64'd0);
    chk("rst_last", 64'(m_axis_tlast), 64'd0);
    chk("rst_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_pulse", 64'(drop_pulse), 64'd0);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    arstn = 1'b1;
    idle(2);

    // 3-beat packet to port 2, then back-to-back packets across ports.
    strict = 1;
    send_beat(2'd2, 32'hA0, 1'b0, 2, 1'b1);
    send_beat(2'd2, 32'hA1, 1'b0, 2, 1'b0);
    send_beat(2'd2, 32'hA2, 1'b1, 2, 1'b0);
    send_pkt(0, 2, -1, 0);
    send_pkt(2, 2, -1, 0);
    // Mid-packet tdest change (even to an invalid index) is ignored.
    send_pkt(1, 4, 3, 0);
    idle(3);

    // Backpressure on port 1 only.
    strict = 0;
    send_beat(2'd1, 32'hB0, 1'b0, 1, 1'b1);
    m_axis_tready = 3'b101;
    s_axis_tvalid = 1'b1;
    s_axis_tdest  = 2'd1;
    s_axis_tdata  = 32'hB1;
    s_axis_tlast  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_tready", 64'(s_axis_tready), 64'd0);
      chk("bp_valid", 64'(m_axis_tvalid), 64'b010);
      @(posedge clk);
      #1;
    end
    m_axis_tready = '1;
    send_beat(2'd1, 32'hB1, 1'b0, 1, 1'b0);
    send_beat(2'd2, 32'hB2, 1'b1, 1, 1'b0);
    idle(3);

    // Drops: 3-beat and 1-beat packets to port 3, then a packet to port 0.
    strict = 1;
    send_pkt(3, 3, -1, 0);
    send_pkt(3, 1, -1, 0);
    send_pkt(0, 3, -1, 0);
    idle(3);
    @(negedge clk);
    chk("drop_cnt_dir", 64'(drop_cnt), 64'd2);
    @(posedge clk);
    #1;

    // Reset with beat 1 of a port-2 packet still in the output stage.
    send_beat(2'd2, 32'hC0, 1'b0, 2, 1'b1);
    send_beat(2'd0, 32'hC1, 1'b0, 2, 1'b0);
    m_axis_tready = '0;
    s_axis_tvalid = 1'b0;
    #1 arstn = 1'b0;
    sb_q.delete();
    lat_q.delete();
    pq.delete();
    exp_cnt = 0;
    @(negedge clk);
    chk("rstmid_valid", 64'(m_axis_tvalid), 64'd0);
    chk("rstmid_cnt", 64'(drop_cnt), 64'd0);
    @(posedge clk);
    #1;
    arstn = 1'b1;
    m_axis_tready = '1;
    idle(1);
    send_pkt(1, 3, -1, 0);
    idle(3);

    // Randomized traffic with random backpressure and gaps.
    strict = 0;
    rdy_rand = 1;
    for (int p = 0; p < 250; p++) begin
      send_pkt(int'($urandom_range(0, 3)), int'($urandom_range(1, 5)), -1, 1);
      if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
    end
    s_axis_tvalid = 1'b0;
    rdy_rand = 0;
    @(posedge clk);
    #2;
    m_axis_tready = '1;
    idle(20);

    @(negedge clk);
    chk("drain_sb", 64'(sb_q.size()), 64'd0);
    chk("drain_pulses", 64'(pq.size()), 64'd0);
    chk("final_cnt", 64'(drop_cnt), 64'(exp_cnt));
    chk("final_idle", 64'(m_axis_tvalid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_split_dest.md
Name: axis_split_dest

Overview:
- Packet-aware AXI-Stream demultiplexer: one slave stream fans out to MASTER_NUM master streams. It is the return-direction counterpart of the round-robin join arbiter.
- The destination comes from s_axis_tdest on the first beat of each packet. It is held for the rest of the packet, through tlast.
- A single registered output stage gives 1-cycle latency and full throughput. Packets addressed to a non-existent port are consumed and dropped, and each dropped packet is counted.

Parameters:
MASTER_NUM, 4, number of master output ports (>=2)
DATA_WIDTH, 32, tdata width
DEST_WIDTH, $clog2(MASTER_NUM), s_axis_tdest width
CNT_WIDTH, 16, width of dropped-packet counter

Ports:
clk  input  1  clock, all logic on rising edge
arstn  input  1  asynchronous active-low reset
s_axis_tdata  input  DATA_WIDTH  slave data
s_axis_tvalid  input  1  slave valid
s_axis_tready  output  1  slave ready
s_axis_tlast  input  1  slave end of packet
s_axis_tdest  input  DEST_WIDTH  destination port index, sampled on first beat only
m_axis_tdata  output  DATA_WIDTH  registered data, broadcast to all masters
m_axis_tlast  output  1  registered last, broadcast
m_axis_tvalid  output  MASTER_NUM  per-port valid, at most one bit set
m_axis_tready  input  MASTER_NUM  per-port ready
drop_cnt  output  CNT_WIDTH  dropped packets, saturating
drop_pulse  output  1  1-cycle pulse per dropped packet (registered)

Behaviour:
- Reset (async assert, sync release via arstn):
  - Output stage: ov=0, osel=0, od=0, ol=0.
  - Control: sop=1, route=0, dropping=0.
  - Statistics: drop_cnt=0, drop_pulse=0.
  - Therefore m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
- Handshake definitions:
  - s_hs = s_axis_tvalid & s_axis_tready.
  - m_hs = ov & |(osel & m_axis_tready).
- Destination select:
  - When sop=1: sel_idx = s_axis_tdest.
  - Otherwise: sel_idx = route.
- Drop decision:
  - drop_now = (sop & s_axis_tvalid & s_axis_tdest >= MASTER_NUM) | dropping.
- Ready: s_axis_tready = drop_now ? 1 : (~ov | m_hs). Output ready is combinational through the selected port's tready only.
- Forward beat (s_hs & ~drop_now):
  - Next cycle: ov=1, od=s_axis_tdata, ol=s_axis_tlast, osel=onehot(sel_idx).
  - If sop: route<=s_axis_tdest.
  - sop<=s_axis_tlast.
- Empty after accept: m_hs & ~(s_hs & ~drop_now) -> ov<=0. osel and od keep their values; their content is don't-care.
- Stalled output: while ov & ~m_hs, od, ol and osel are held stable. Readiness of non-selected ports has no effect.
- Drop beat (s_hs & drop_now):
  - The beat is not written to the output stage.
  - On the first beat of a dropped packet: drop_cnt<=drop_cnt+1, saturating at all-ones, and drop_pulse<=1 for one cycle.
  - dropping<=~s_axis_tlast and sop<=s_axis_tlast.
  - A single-beat dropped packet returns to sop immediately.
- Stable route: tdest on non-first beats is ignored; a change mid-packet never changes the route.
- Latency and throughput:
  - Latency from s_hs to m_axis_tvalid is exactly 1 cycle.
  - Back-to-back beats and packets run at 1 beat/cycle when the selected port is ready, including a change of port at a packet boundary, with no bubble.
- Invalid destinations: when MASTER_NUM is a power of 2, no tdest value is invalid, and the drop logic is present but never triggers.
- Reset mid-packet: the in-flight output beat is discarded, and the next slave beat is treated as sop.
- Protocol: once asserted, m_axis_tvalid stays high until m_hs (AXI-Stream rule).

Test Plan:
- Reset with arstn=0 while s_axis_tvalid=1 -> s_axis_tready=1 (output empty), m_axis_tvalid=0000, drop_cnt=0. Release, then drive a 3-beat packet, tdest=2, data A0/A1/A2, all readies=1 -> m_axis_tvalid=0100 for 3 consecutive cycles starting 1 cycle after the first s_hs, and m_axis_tlast=1 only with A2.
- Back-to-back: 2-beat packet to dest 0, then 2-beat packet to dest 3, s_axis_tvalid held 1 -> m_axis_tvalid sequence 0001,0001,1000,1000 with no idle cycle.
- Mid-packet tdest change: 4-beat packet, tdest=1 on beat0 and tdest=3 on beats1-3 -> all 4 beats on port 1 only.
- Backpressure: packet to dest 1, m_axis_tready[1]=0 for 5 cycles while the other tready bits are 1 -> s_axis_tready=0, m_axis_tdata stable, no beat lost or duplicated after release.
- MASTER_NUM=3, DEST_WIDTH=2: 3-beat packet with tdest=3, then 1-beat packet with tdest=3, then a packet to dest 0 -> s_axis_tready=1 throughout the dropped packets, m_axis_tvalid=000 for them, drop_cnt=2, two drop_pulses, and the dest-0 packet is delivered intact.
- Assert arstn=0 after beat 1 of a 4-beat packet to port 2, then send a new packet to port 1 -> port 2 receives nothing further, and port 1 receives the new packet starting with its first beat.
